// File: rtl/melody_sequencer.sv
// Sixteen-note buzzer sequencer: each step sounds for NOTE_TICKS cycles,
// then stays silent for GAP_TICKS cycles. Supports pause, stop and loop.
module melody_sequencer #(
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 1250000,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop,
  output logic [3:0] buz_data,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST =
    CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam bit HAS_GAP = (GAP_TICKS > 0);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       step;
  logic [3:0]       step_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             step_end;
  logic [3:0]       buz_nx;
  logic             en_nx;
  logic             busy_nx;
  logic             done_nx;

  always_comb begin
    state_nx = state;
    step_nx  = step;
    cnt_nx   = cnt;
    step_end = 1'b0;
    if (stop) begin
      state_nx = IDLE;
      step_nx  = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = PLAY;
            step_nx  = '0;
            cnt_nx   = '0;
          end
        end
        PLAY: begin
          if (!pause) begin
            if (cnt == NOTE_LAST) begin
              if (HAS_GAP) begin
                state_nx = GAP;
                cnt_nx   = '0;
              end else begin
                step_end = 1'b1;
              end
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (!pause) begin
            if (cnt == GAP_LAST) begin
              step_end = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
    // Only the last step can wrap the 4-bit step, and only when looping
    if (step_end) begin
      cnt_nx = '0;
      if (step != 4'hf) begin
        state_nx = PLAY;
        step_nx  = step + 4'd1;
      end else if (loop) begin
        state_nx = PLAY;
        step_nx  = '0;
      end else begin
        state_nx = DONE;
        step_nx  = '0;
      end
    end
  end

  always_comb begin
    busy_nx = (state_nx == PLAY) || (state_nx == GAP);
    en_nx   = (state_nx == PLAY) && !pause;
    done_nx = (state_nx == DONE);
    buz_nx  = busy_nx ? step_nx : 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      step     <= '0;
      cnt      <= '0;
      buz_data <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      step     <= step_nx;
      cnt      <= cnt_nx;
      buz_data <= buz_nx;
      enable   <= en_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (with and without a gap)
// compared every cycle against a position-in-melody reference model.
module tb_melody_sequencer;

  localparam int N  = 4;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       start_b = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] buz_a, buz_b;
  logic       en_a, en_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  melody_sequencer #(
    .NOTE_TICKS(N), .GAP_TICKS(2), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause(pause), .loop(loop), .buz_data(buz_a),
    .enable(en_a), .busy(busy_a), .done(done_a)
  );

  melody_sequencer #(
    .NOTE_TICKS(N), .GAP_TICKS(0), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop),
    .pause(pause), .loop(loop), .buz_data(buz_b),
    .enable(en_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: melody position in unpaused ticks, 0 .. 16*period-1
  bit m_run[2];
  int m_pos[2];
  bit m_done[2];
  bit m_pz[2];

  function automatic int per(int i);
    return (i == 0) ? N + 2 : N;
  endfunction

  function automatic logic [6:0] exp_vec(int i);
    logic [3:0] b;
    logic e;
    b = m_run[i] ? 4'(m_pos[i] / per(i)) : 4'd0;
    e = m_run[i] && !m_pz[i] && ((m_pos[i] % per(i)) < N);
    return {b, e, m_run[i], m_done[i]};
  endfunction

  function automatic logic [6:0] obs_vec(int i);
    if (i == 0) return {buz_a, en_a, busy_a, done_a};
    return {buz_b, en_b, busy_b, done_b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_done[i] = 0; m_pz[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      logic st;
      st = (i == 0) ? start : start_b;
      if (!rst) begin
        m_run[i] = 0; m_pos[i] = 0; m_done[i] = 0; m_pz[i] = 0;
      end else begin
        m_pz[i] = pause;
        if (stop) begin
          m_run[i] = 0; m_pos[i] = 0; m_done[i] = 0;
        end else if (m_done[i]) begin
          m_done[i] = 0;
        end else if (!m_run[i]) begin
          if (st) begin
            m_run[i] = 1; m_pos[i] = 0;
          end
        end else if (!pause) begin
          m_pos[i]++;
          if (m_pos[i] == 16 * per(i)) begin
            m_pos[i] = 0;
            if (!loop) begin
              m_run[i] = 0; m_done[i] = 1;
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_vec(i) !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got %h want 00", i, obs_vec(i));
      end
    end
    rst = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_vec(i) !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d got %h want %h",
                 i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_single_melody();
    int done_at, pulses, bad_steps;
    int en_cnt[16];
    int gap_cnt[16];
    foreach (en_cnt[k]) begin en_cnt[k] = 0; gap_cnt[k] = 0; end
    done_at = -1; pulses = 0; bad_steps = 0;
    loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({buz_a, en_a, busy_a, done_a} !== 7'b0000_110) begin
      n_fail++;
      $display("FAIL first_play got %b want 0000110",
               {buz_a, en_a, busy_a, done_a});
    end
    for (int cyc = 0; cyc < 110; cyc++) begin
      n_checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL single_cyc%0d got %h want %h",
                 cyc, obs_vec(0), exp_vec(0));
      end
      if (busy_a && en_a) en_cnt[buz_a]++;
      if (busy_a && !en_a) gap_cnt[buz_a]++;
      if (done_a) begin
        pulses++;
        if (done_at < 0) done_at = cyc;
      end
      tick();
    end
    for (int s = 0; s < 16; s++)
      if (en_cnt[s] != 4 || gap_cnt[s] != 2) bad_steps++;
    n_checks++;
    if (bad_steps != 0) begin
      n_fail++;
      $display("FAIL step_shape bad_steps got %0d want 0", bad_steps);
    end
    n_checks++;
    if (done_at != 96 || pulses != 1) begin
      n_fail++;
      $display("FAIL done_timing at %0d x%0d want 96 x1",
               done_at, pulses);
    end
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after busy got %b want 0", busy_a);
    end
  endtask

  task automatic test_loop();
    int pulses;
    pulses = 0;
    loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      n_checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL loop_cyc%0d got %h want %h",
                 cyc, obs_vec(0), exp_vec(0));
      end
      if (done_a) pulses++;
      if (cyc == 96) begin
        n_checks++;
        if ({buz_a, en_a, busy_a} !== 6'b0000_11) begin
          n_fail++;
          $display("FAIL loop_wrap got %b want 000011",
                   {buz_a, en_a, busy_a});
        end
      end
      tick();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL loop_no_done got %0d want 0", pulses);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    int done_at, en3, low_win;
    done_at = -1; en3 = 0; low_win = 0;
    loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 121; cyc++) begin
      n_checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL pause_cyc%0d got %h want %h",
                 cyc, obs_vec(0), exp_vec(0));
      end
      if (busy_a && en_a && buz_a == 4'd3) en3++;
      if (cyc >= 20 && cyc < 30 && !en_a && busy_a) low_win++;
      if (done_a && done_at < 0) done_at = cyc;
      pause = (cyc >= 19 && cyc < 29);
      tick();
    end
    pause = 1'b0;
    n_checks++;
    if (done_at != 106 || en3 != 4 || low_win != 10) begin
      n_fail++;
      $display("FAIL pause_len done %0d en3 %0d low %0d want 106 4 10",
               done_at, en3, low_win);
    end
  endtask

  task automatic test_stop();
    int pulses;
    pulses = 0;
    loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 46; cyc++) begin
      n_checks++;
      if (obs_vec(0) !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL stop_cyc%0d got %h want %h",
                 cyc, obs_vec(0), exp_vec(0));
      end
      tick();
    end
    n_checks++;
    if ({buz_a, en_a, busy_a} !== 6'b0111_01) begin
      n_fail++;
      $display("FAIL stop_in_gap got %b want 011101",
               {buz_a, en_a, busy_a});
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (obs_vec(0) !== 7'd0) begin
      n_fail++;
      $display("FAIL stop_out got %h want 00", obs_vec(0));
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (done_a) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_quiet done %0d busy %b want 0 0", pulses, busy_a);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({buz_a, en_a, busy_a, done_a} !== 7'b0000_110) begin
      n_fail++;
      $display("FAIL restart got %b want 0000110",
               {buz_a, en_a, busy_a, done_a});
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (61) tick();
    n_checks++;
    if ({buz_a, en_a, busy_a} !== 6'b1010_11) begin
      n_fail++;
      $display("FAIL pre_reset got %b want 101011", {buz_a, en_a, busy_a});
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs_vec(0) !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 00", obs_vec(0));
    end
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      n_checks++;
      if (obs_vec(0) !== exp_vec(0) || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle got %h want %h",
                 obs_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_gap0_back_to_back();
    int pulses, run, bad_len, en_drop;
    pulses = 0; run = 0; bad_len = 0; en_drop = 0;
    loop = 1'b0;
    start_b = 1'b1;
    for (int cyc = 0; cyc < 220; cyc++) begin
      tick();
      n_checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL gap0_cyc%0d got %h want %h",
                 cyc, obs_vec(1), exp_vec(1));
      end
      if (busy_b) begin
        run++;
        if (!en_b) en_drop++;
      end
      if (done_b) begin
        pulses++;
        if (run != 64) bad_len++;
        run = 0;
      end
    end
    start_b = 1'b0;
    n_checks++;
    if (pulses != 3 || bad_len != 0 || en_drop != 0) begin
      n_fail++;
      $display("FAIL gap0_b2b pulses %0d badlen %0d drops %0d want 3 0 0",
               pulses, bad_len, en_drop);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stop    = ($urandom_range(0, 99) < 2);
      pause   = ($urandom_range(0, 99) < 15);
      start   = ($urandom_range(0, 99) < 10);
      start_b = ($urandom_range(0, 99) < 10);
      rst     = ($urandom_range(0, 999) >= 3);
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL random_cyc%0d dut%0d got %h want %h",
                   cyc, i, obs_vec(i), exp_vec(i));
        end
      end
    end
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    start_b = 1'b0; rst = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_melody();
    test_loop();
    test_pause();
    test_stop();
    test_async_reset();
    test_gap0_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
